instr_mem_loader: RTL and testbench

//  Boot loader and port arbiter for the 64x17 instruction memory. On a start pulse it

---
 rtl/proc_pkg.sv | 34 +++
 rtl/instr_mem_loader_if.sv | 41 ++++
 rtl/imem_port_mux.sv | 40 ++++
 rtl/instr_mem_loader.sv | 159 +++++++++++++++
 tb/tb_instr_mem_loader.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/proc_pkg.sv
// ---------------------------------------------------------------------------
// proc_pkg
// Shared definitions for the instruction-memory boot loader slice.
//   INSTR_W      width of one instruction word
//   IMEM_ADDR_W  instruction memory address width
//   IMEM_DEPTH   number of words in the instruction memory
//   WCOUNT_W     width of the words-loaded counter (must hold IMEM_DEPTH)
//   loader_state_t  loader FSM state encoding
//   length_ok()  legality test for the program-length byte
// ---------------------------------------------------------------------------
package proc_pkg;

  localparam int INSTR_W     = 17;
  localparam int IMEM_ADDR_W = 6;
  localparam int IMEM_DEPTH  = 64;
  localparam int WCOUNT_W    = 7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GET_LEN,
    ST_GET_B0,
    ST_GET_B1,
    ST_GET_B2,
    ST_WRITE,
    ST_DONE,
    ST_ERROR
  } loader_state_t;

  // A program must contain at least one word and must fit in the memory.
  function automatic logic length_ok(input logic [7:0] n, input int depth);
    return (n != 8'd0) && ({24'd0, n} <= unsigned'(depth));
  endfunction

endpackage

// File: rtl/instr_mem_loader_if.sv
// ---------------------------------------------------------------------------
// instr_mem_loader_if
// Bundles every non-clock signal of the boot loader.
//   start_load   begin a load (1-cycle pulse)
//   rx_valid/rx_byte/rx_ready   byte stream from the UART receiver
//   cpu_addr/cpu_read           CPU fetch port
//   mem_addr/mem_wdata/mem_we/mem_read   instruction memory port
//   cpu_hold/load_done/load_error/words_loaded   status towards the CPU
// Modports: slave = the loader itself, master = everything around it.
// ---------------------------------------------------------------------------
interface instr_mem_loader_if;
  import proc_pkg::*;

  logic                   start_load;
  logic                   rx_valid;
  logic [7:0]             rx_byte;
  logic                   rx_ready;
  logic [IMEM_ADDR_W-1:0] cpu_addr;
  logic                   cpu_read;
  logic [IMEM_ADDR_W-1:0] mem_addr;
  logic [INSTR_W-1:0]     mem_wdata;
  logic                   mem_we;
  logic                   mem_read;
  logic                   cpu_hold;
  logic                   load_done;
  logic                   load_error;
  logic [WCOUNT_W-1:0]    words_loaded;

  modport slave (
    input  start_load, rx_valid, rx_byte, cpu_addr, cpu_read,
    output rx_ready, mem_addr, mem_wdata, mem_we, mem_read,
           cpu_hold, load_done, load_error, words_loaded
  );

  modport master (
    output start_load, rx_valid, rx_byte, cpu_addr, cpu_read,
    input  rx_ready, mem_addr, mem_wdata, mem_we, mem_read,
           cpu_hold, load_done, load_error, words_loaded
  );

endinterface

// File: rtl/imem_port_mux.sv
// ---------------------------------------------------------------------------
// imem_port_mux
// Combinational owner select for the instruction memory port.
//   cpu_hold  in   1       1 = loader owns the port, 0 = CPU owns it
//   cpu_addr  in   ADDR_W  CPU fetch address
//   cpu_read  in   1       CPU fetch strobe
//   ldr_addr  in   ADDR_W  loader write address
//   ldr_we    in   1       loader write enable
//   mem_addr  out  ADDR_W  memory address
//   mem_read  out  1       memory read strobe
//   mem_we    out  1       memory write enable
// ---------------------------------------------------------------------------
module imem_port_mux #(
  parameter int ADDR_W = 6
) (
  input  logic              cpu_hold,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_read,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic              ldr_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_read,
  output logic              mem_we
);

  // While the CPU is held the loader drives the address and may write, and
  // fetches are suppressed; otherwise the CPU fetch port passes straight
  // through and writes are impossible.
  always_comb begin
    mem_addr = cpu_addr;
    mem_read = cpu_read;
    mem_we   = 1'b0;
    if (cpu_hold) begin
      mem_addr = ldr_addr;
      mem_read = 1'b0;
      mem_we   = ldr_we;
    end
  end

endmodule

// File: rtl/instr_mem_loader.sv
// ---------------------------------------------------------------------------
// instr_mem_loader
// Boot loader and port arbiter for the instruction memory. After start_load
// it receives a length byte N followed by N instructions of 3 bytes each
// (bit 16 from byte 0 bit 0, then bits 15:8, then bits 7:0) and writes them
// to consecutive addresses from 0, holding the CPU off the fetch port. Outside
// a load the CPU fetch port passes straight through to the memory.
// Ports:
//   clk   in  system clock, rising edge
//   rst   in  asynchronous active-high reset
//   bus   instr_mem_loader_if.slave (byte stream, CPU port, memory port, status)
// ---------------------------------------------------------------------------
module instr_mem_loader
  import proc_pkg::*;
#(
  parameter int ADDR_W = IMEM_ADDR_W,
  parameter int DATA_W = INSTR_W,
  parameter int DEPTH  = IMEM_DEPTH
) (
  input  logic                clk,
  input  logic                rst,
  instr_mem_loader_if.slave   bus
);

  loader_state_t       state_q, state_d;
  logic [ADDR_W-1:0]   addr_q;
  logic [7:0]          len_q;
  logic [WCOUNT_W-1:0] words_q;
  logic [DATA_W-1:0]   instr_q;

  logic                rx_ready;
  logic                hold;
  logic                accept;
  logic                start_ok;
  logic                last_word;
  logic                ldr_we;
  logic [ADDR_W-1:0]   mux_addr;
  logic                mux_read;
  logic                mux_we;

  assign accept    = bus.rx_valid && rx_ready;
  assign start_ok  = bus.start_load &&
                     (state_q inside {ST_IDLE, ST_DONE, ST_ERROR});
  assign last_word = (({1'b0, words_q} + 8'd1) == len_q);
  assign ldr_we    = (state_q == ST_WRITE);

  // State register; reset drops straight back to IDLE, abandoning any load
  // in progress (whatever was already written stays in memory).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and Moore outputs. Receive states wait indefinitely for a byte;
  // WRITE always lasts one cycle and never takes a byte, so the source holds
  // it until GET_B0. The CPU is held from GET_LEN through WRITE and in ERROR.
  always_comb begin
    state_d  = state_q;
    rx_ready = 1'b0;
    hold     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start_ok) state_d = ST_GET_LEN;
      end
      ST_GET_LEN: begin
        rx_ready = 1'b1;
        hold     = 1'b1;
        if (accept) begin
          state_d = length_ok(bus.rx_byte, DEPTH) ? ST_GET_B0 : ST_ERROR;
        end
      end
      ST_GET_B0: begin
        rx_ready = 1'b1;
        hold     = 1'b1;
        if (accept) state_d = ST_GET_B1;
      end
      ST_GET_B1: begin
        rx_ready = 1'b1;
        hold     = 1'b1;
        if (accept) state_d = ST_GET_B2;
      end
      ST_GET_B2: begin
        rx_ready = 1'b1;
        hold     = 1'b1;
        if (accept) state_d = ST_WRITE;
      end
      ST_WRITE: begin
        hold    = 1'b1;
        state_d = last_word ? ST_DONE : ST_GET_B0;
      end
      ST_DONE: begin
        if (start_ok) state_d = ST_GET_LEN;
      end
      ST_ERROR: begin
        hold = 1'b1;
        if (start_ok) state_d = ST_GET_LEN;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Datapath: a new load clears the write pointer and word count, the length
  // byte is latched as received, the instruction is assembled byte by byte,
  // and each WRITE cycle bumps the pointer and count. The last write lands
  // at N-1, so the pointer never needs to wrap while it is in use.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      len_q   <= '0;
      words_q <= '0;
      instr_q <= '0;
    end else begin
      if (start_ok) begin
        addr_q  <= '0;
        words_q <= '0;
      end
      unique case (state_q)
        ST_GET_LEN: if (accept) len_q <= bus.rx_byte;
        ST_GET_B0:  if (accept) instr_q[DATA_W-1] <= bus.rx_byte[0];
        ST_GET_B1:  if (accept) instr_q[DATA_W-2 -: 8] <= bus.rx_byte;
        ST_GET_B2:  if (accept) instr_q[7:0] <= bus.rx_byte;
        ST_WRITE: begin
          addr_q  <= addr_q + ADDR_W'(1);
          words_q <= words_q + WCOUNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  imem_port_mux #(
    .ADDR_W (ADDR_W)
  ) u_port_mux (
    .cpu_hold (hold),
    .cpu_addr (bus.cpu_addr),
    .cpu_read (bus.cpu_read),
    .ldr_addr (addr_q),
    .ldr_we   (ldr_we),
    .mem_addr (mux_addr),
    .mem_read (mux_read),
    .mem_we   (mux_we)
  );

  assign bus.rx_ready     = rx_ready;
  assign bus.cpu_hold     = hold;
  assign bus.mem_addr     = mux_addr;
  assign bus.mem_read     = mux_read;
  assign bus.mem_we       = mux_we;
  assign bus.mem_wdata    = instr_q;
  assign bus.load_done    = (state_q == ST_DONE);
  assign bus.load_error   = (state_q == ST_ERROR);
  assign bus.words_loaded = words_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// ---------------------------------------------------------------------------
// tb_instr_mem_loader
// Drives byte streams into instr_mem_loader, models the instruction memory,
// and checks every memory write against a queue of expected (addr, data)
// pairs pushed when the corresponding bytes are issued. Status outputs are
// compared against hand-computed constants.
// ---------------------------------------------------------------------------
module tb_instr_mem_loader;
  import proc_pkg::*;

  logic clk = 1'b0;
  logic rst;

  int checks = 0;
  int errors = 0;

  logic [IMEM_ADDR_W+INSTR_W-1:0] exp_q[$];
  logic [IMEM_ADDR_W+INSTR_W-1:0] mon_exp;
  logic [INSTR_W-1:0]             mem_model [IMEM_DEPTH];

  instr_mem_loader_if bus ();

  instr_mem_loader dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // 10 ns system clock.
  always #5 clk = ~clk;

  // Instruction memory model: writes land on the rising edge like the real
  // write port, and nothing ever clears it.
  always @(posedge clk) begin
    if (bus.mem_we) mem_model[bus.mem_addr] <= bus.mem_wdata;
  end

  // Write monitor: every write the loader presents is matched against the
  // oldest expected write; fetches must be suppressed while writing.
  always @(negedge clk) begin
    if (!rst && bus.mem_we) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL write_unexpected got addr=%0d data=%05h, required no write",
                 bus.mem_addr, bus.mem_wdata);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({bus.mem_addr, bus.mem_wdata} !== mon_exp || bus.mem_read !== 1'b0) begin
          errors++;
          $display("[TB] FAIL write got addr=%0d data=%05h rd=%b, required addr=%0d data=%05h rd=0",
                   bus.mem_addr, bus.mem_wdata, bus.mem_read,
                   mon_exp[INSTR_W +: IMEM_ADDR_W], mon_exp[INSTR_W-1:0]);
        end
      end
    end
  end

  // Hard stop in case something wedges outside a bounded wait.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %0h required %0h", name, act, exp);
    end
  endtask

  // Present one byte after 'gap' idle cycles and hold it until accepted.
  // Entered and left at 1 ns after a rising edge.
  task automatic applyStimulus(input logic [7:0] b, input int gap);
    bit ok;
    bus.rx_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    bus.rx_valid = 1'b1;
    bus.rx_byte  = b;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.rx_ready) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("[TB] FAIL rx_handshake got no rx_ready in 50 cycles, required accept of %02h", b);
    end
  endtask

  task automatic sendWord(input logic [7:0] b0, input logic [7:0] b1,
                          input logic [7:0] b2, input logic [5:0] addr,
                          input int maxgap);
    exp_q.push_back({addr, b0[0], b1, b2});
    applyStimulus(b0, (maxgap == 0) ? 0 : int'($urandom_range(maxgap, 0)));
    applyStimulus(b1, (maxgap == 0) ? 0 : int'($urandom_range(maxgap, 0)));
    applyStimulus(b2, (maxgap == 0) ? 0 : int'($urandom_range(maxgap, 0)));
  endtask

  task automatic pulseStart();
    bus.start_load = 1'b1;
    @(posedge clk);
    #1;
    bus.start_load = 1'b0;
  endtask

  // Wait (bounded) for the load to finish, either way.
  task automatic waitEnd();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.load_done || bus.load_error) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    if (!ok) begin
      checks++;
      errors++;
      $display("[TB] FAIL load_end got no done/error in 40 cycles, required one");
    end
  endtask

  // Full 64-word program: word i = {i[0], i, 255-i}; byte 0 carries junk in
  // bits 7:1 that must be ignored. Optionally pulses start_load mid-load.
  task automatic runBig(input int maxgap, input bit mid_start);
    applyStimulus(8'd64, 0);
    for (int i = 0; i < 64; i++) begin
      if (mid_start && i == 20) begin
        pulseStart();
        checkOutput("mid_start_hold", 32'(bus.cpu_hold), 32'd1);
        checkOutput("mid_start_words", 32'(bus.words_loaded), 32'd20);
      end
      sendWord(8'hA0 | 8'(i[0]), 8'(i), 8'(8'hFF - i[7:0]), 6'(i), maxgap);
    end
  endtask

  task automatic checkBigImage(input string name);
    int bad;
    logic [INSTR_W-1:0] want;
    bad = 0;
    for (int i = 0; i < 64; i++) begin
      want = {i[0], i[7:0], 8'(8'hFF - i[7:0])};
      if (mem_model[i] !== want) bad++;
    end
    checkOutput(name, 32'(bad), 32'd0);
  endtask

  // Directed sequence: pass-through, a 2-word load, illegal lengths, a full
  // 64-word load with and without byte gaps, and a reset mid-load.
  initial begin
    bus.start_load = 1'b0;
    bus.rx_valid   = 1'b0;
    bus.rx_byte    = 8'h00;
    bus.cpu_addr   = '0;
    bus.cpu_read   = 1'b0;
    for (int i = 0; i < IMEM_DEPTH; i++) mem_model[i] = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Reset state and pass-through.
    checkOutput("rst_cpu_hold", 32'(bus.cpu_hold), 32'd0);
    checkOutput("rst_rx_ready", 32'(bus.rx_ready), 32'd0);
    checkOutput("rst_load_done", 32'(bus.load_done), 32'd0);
    checkOutput("rst_load_error", 32'(bus.load_error), 32'd0);
    checkOutput("rst_words", 32'(bus.words_loaded), 32'd0);
    checkOutput("rst_mem_we", 32'(bus.mem_we), 32'd0);
    rst = 1'b0;
    bus.cpu_addr = 6'd5;
    bus.cpu_read = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("idle_mem_addr", 32'(bus.mem_addr), 32'd5);
    checkOutput("idle_mem_read", 32'(bus.mem_read), 32'd1);
    checkOutput("idle_mem_we", 32'(bus.mem_we), 32'd0);

    // Two-word program.
    pulseStart();
    checkOutput("load_cpu_hold", 32'(bus.cpu_hold), 32'd1);
    checkOutput("load_mem_read", 32'(bus.mem_read), 32'd0);
    checkOutput("load_rx_ready", 32'(bus.rx_ready), 32'd1);
    exp_q.push_back({6'd0, 17'h12345});
    exp_q.push_back({6'd1, 17'h0ABCD});
    applyStimulus(8'h02, 0);
    applyStimulus(8'h01, 0);
    applyStimulus(8'h23, 0);
    applyStimulus(8'h45, 0);
    applyStimulus(8'h00, 0);
    applyStimulus(8'hAB, 0);
    applyStimulus(8'hCD, 0);
    waitEnd();
    checkOutput("two_done", 32'(bus.load_done), 32'd1);
    checkOutput("two_words", 32'(bus.words_loaded), 32'd2);
    checkOutput("two_hold", 32'(bus.cpu_hold), 32'd0);
    checkOutput("two_passthru", 32'(bus.mem_addr), 32'd5);
    checkOutput("two_pending", 32'(exp_q.size()), 32'd0);
    checkOutput("two_mem0", 32'(mem_model[0]), 32'h12345);
    checkOutput("two_mem1", 32'(mem_model[1]), 32'h0ABCD);

    // Illegal lengths: zero and DEPTH+1.
    pulseStart();
    checkOutput("restart_done_clr", 32'(bus.load_done), 32'd0);
    checkOutput("restart_words_clr", 32'(bus.words_loaded), 32'd0);
    applyStimulus(8'h00, 0);
    waitEnd();
    checkOutput("len0_error", 32'(bus.load_error), 32'd1);
    checkOutput("len0_hold", 32'(bus.cpu_hold), 32'd1);
    checkOutput("len0_rx_ready", 32'(bus.rx_ready), 32'd0);
    checkOutput("len0_mem_read", 32'(bus.mem_read), 32'd0);
    checkOutput("len0_done", 32'(bus.load_done), 32'd0);
    pulseStart();
    checkOutput("len0_error_clr", 32'(bus.load_error), 32'd0);
    applyStimulus(8'h41, 0);
    waitEnd();
    checkOutput("len65_error", 32'(bus.load_error), 32'd1);
    checkOutput("len65_hold", 32'(bus.cpu_hold), 32'd1);
    checkOutput("len65_rx_ready", 32'(bus.rx_ready), 32'd0);
    pulseStart();
    checkOutput("len65_error_clr", 32'(bus.load_error), 32'd0);
    checkOutput("len65_restart_hold", 32'(bus.cpu_hold), 32'd1);
    applyStimulus(8'h01, 0);
    sendWord(8'h00, 8'h00, 8'h07, 6'd0, 0);
    waitEnd();
    checkOutput("one_done", 32'(bus.load_done), 32'd1);
    checkOutput("one_words", 32'(bus.words_loaded), 32'd1);
    checkOutput("one_pending", 32'(exp_q.size()), 32'd0);

    // Full memory, back-to-back bytes.
    pulseStart();
    runBig(0, 1'b0);
    waitEnd();
    checkOutput("full_done", 32'(bus.load_done), 32'd1);
    checkOutput("full_words", 32'(bus.words_loaded), 32'd64);
    checkOutput("full_error", 32'(bus.load_error), 32'd0);
    checkOutput("full_pending", 32'(exp_q.size()), 32'd0);
    checkOutput("full_mem63", 32'(mem_model[63]), 32'h13FC0);
    checkBigImage("full_image_bad_words");

    // Same program with random gaps and an ignored mid-load start.
    for (int i = 0; i < IMEM_DEPTH; i++) mem_model[i] = '0;
    pulseStart();
    runBig(5, 1'b1);
    waitEnd();
    checkOutput("gap_done", 32'(bus.load_done), 32'd1);
    checkOutput("gap_words", 32'(bus.words_loaded), 32'd64);
    checkOutput("gap_pending", 32'(exp_q.size()), 32'd0);
    checkBigImage("gap_image_bad_words");

    // Reset after 2 of 3 bytes of word 1.
    pulseStart();
    applyStimulus(8'h02, 0);
    sendWord(8'hAA, 8'hBB, 8'hCC, 6'd0, 0);
    applyStimulus(8'h01, 0);
    applyStimulus(8'h02, 0);
    checkOutput("mid_hold", 32'(bus.cpu_hold), 32'd1);
    checkOutput("mid_words", 32'(bus.words_loaded), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("rstmid_hold", 32'(bus.cpu_hold), 32'd0);
    checkOutput("rstmid_words", 32'(bus.words_loaded), 32'd0);
    checkOutput("rstmid_rx_ready", 32'(bus.rx_ready), 32'd0);
    checkOutput("rstmid_passthru", 32'(bus.mem_addr), 32'd5);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("rstmid_done", 32'(bus.load_done), 32'd0);
    checkOutput("rstmid_mem0", 32'(mem_model[0]), 32'h0BBCC);
    checkOutput("rstmid_mem1", 32'(mem_model[1]), 32'h101FE);
    checkOutput("rstmid_pending", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
